// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch stage bus: memory port, redirect, decode handshake (FETCH_PERF_EN adds counters)
interface fetch_unit_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [DATA_WIDTH-1:0] imem_data;
  logic                  redirect;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  out_ready;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] instr;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] pc_plus1;
`ifdef FETCH_PERF_EN
  logic [31:0]           perf_fetched;
  logic [31:0]           perf_stall;

  modport master (
    output imem_addr, input imem_data,
    input redirect, input redirect_pc, input out_ready,
    output out_valid, output instr, output pc, output pc_plus1,
    output perf_fetched, output perf_stall
  );
  modport slave (
    input imem_addr, output imem_data,
    output redirect, output redirect_pc, output out_ready,
    input out_valid, input instr, input pc, input pc_plus1,
    input perf_fetched, input perf_stall
  );
`else
  modport master (
    output imem_addr, input imem_data,
    input redirect, input redirect_pc, input out_ready,
    output out_valid, output instr, output pc, output pc_plus1
  );
  modport slave (
    input imem_addr, output imem_data,
    output redirect, output redirect_pc, output out_ready,
    input out_valid, input instr, input pc, input pc_plus1
  );
`endif
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, stall hold, redirect squash; FETCH_PERF_EN adds perf counters
module fetch_unit #(
  parameter int                    ADDR_WIDTH = 10,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);
  typedef enum logic {FILL, RUN} state_t;

  localparam logic [ADDR_WIDTH-1:0] PC_ONE = 1;

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] pc_next;
  logic                  valid;

  // A redirect squashes whatever is presented this cycle: it is wrong-path.
  always_comb begin
    valid = (state == RUN) && !bus.redirect && !rst;
  end

  // Holding the PC on a stall makes the memory re-read the same word.
  always_comb begin
    pc_next = pc_q + PC_ONE;
    if (rst)
      pc_next = RESET_PC;
    else if (bus.redirect)
      pc_next = bus.redirect_pc;
    else if (state == FILL)
      pc_next = pc_q;
    else if (valid && !bus.out_ready)
      pc_next = pc_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL;
      pc_q  <= RESET_PC;
    end else begin
      state <= RUN;
      pc_q  <= pc_next;
    end
  end

  assign bus.imem_addr = pc_next;
  assign bus.out_valid = valid;
  assign bus.instr     = valid ? bus.imem_data : '0;
  assign bus.pc        = pc_q;
  assign bus.pc_plus1  = pc_q + PC_ONE;

`ifdef FETCH_PERF_EN
  logic [31:0] fetched_q;
  logic [31:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetched_q <= '0;
      stall_q   <= '0;
    end else begin
      if (valid && bus.out_ready && fetched_q != 32'hFFFF_FFFF)
        fetched_q <= fetched_q + 32'd1;
      if (valid && !bus.out_ready && stall_q != 32'hFFFF_FFFF)
        stall_q <= stall_q + 32'd1;
    end
  end

  assign bus.perf_fetched = fetched_q;
  assign bus.perf_stall   = stall_q;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - table-driven bench for fetch_unit with a transfer scoreboard
module tb_fetch_unit;
  localparam int AW = 10;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_unit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  fetch_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC(10'd0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Instruction memory model: mem[k] = k + 0x100, one-cycle read latency.
  always @(posedge clk) bus.imem_data <= 32'h100 + 32'(bus.imem_addr);

  typedef struct {
    logic          rst;
    logic          redir;
    logic [AW-1:0] rpc;
    logic          rdy;
    logic          valid;
    logic [AW-1:0] pc;
    logic [AW-1:0] addr;
  } vec_t;

  typedef struct {
    logic [AW-1:0] pc;
    logic [DW-1:0] instr;
  } xfer_t;

  vec_t  vecs[$];
  xfer_t sb[$];
  int    errors = 0;
  int    checks = 0;
  int    row = 0;
  int    exp_fetched = 0;
  int    exp_stall = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic rd, input int rp, input logic rdy,
                     input logic v, input int p, input int a);
    vec_t x;
    x.rst = r; x.redir = rd; x.rpc = AW'(rp); x.rdy = rdy;
    x.valid = v; x.pc = AW'(p); x.addr = AW'(a);
    vecs.push_back(x);
  endtask

  // Free-running accepted instructions starting at pc=first, wrapping at 2^AW.
  task automatic run(input int first, input int n);
    for (int i = 0; i < n; i++)
      add(1'b0, 1'b0, 0, 1'b1, 1'b1, (first + i) % 1024, (first + i + 1) % 1024);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t          v;
    xfer_t         got;
    logic [AW-1:0] exp_p1;

    // rst redir rpc rdy | valid pc addr
    add(0, 0, 0, 1, 0, 0, 0);            // FILL bubble after reset
    run(0, 5);
    repeat (3) add(0, 0, 0, 0, 1, 5, 5); // stall at pc=5
    add(0, 0, 0, 1, 1, 5, 6);
    run(6, 1);
    add(0, 1, 20, 1, 0, 7, 20);          // redirect squashes pc=7
    run(20, 2);
    add(0, 1, 1022, 1, 0, 22, 1022);
    run(1022, 4);                        // 1022, 1023, 0, 1
    add(0, 1, 100, 1, 0, 2, 100);        // back-to-back redirects
    add(0, 1, 200, 1, 0, 100, 200);
    run(200, 1);
    add(0, 0, 0, 0, 1, 201, 201);        // redirect during stall
    add(0, 1, 50, 0, 0, 201, 50);
    run(50, 1);
    add(0, 0, 0, 0, 1, 51, 51);          // reset during stall with redirect
    add(1, 1, 300, 0, 0, 51, 0);
    add(0, 0, 0, 1, 0, 0, 0);
    run(0, 2);
    add(1, 0, 0, 1, 0, 2, 0);            // redirect during FILL
    add(0, 1, 30, 1, 0, 0, 30);
    run(30, 5);                          // 10 transfers + 3 stalls since reset
    repeat (3) add(0, 0, 0, 0, 1, 35, 35);
    add(0, 0, 0, 1, 1, 35, 36);
    run(36, 4);

    rst = 1'b1;
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      row = i;
      @(posedge clk);
      #1;
      rst = v.rst;
      bus.redirect = v.redir;
      bus.redirect_pc = v.rpc;
      bus.out_ready = v.rdy;
      if (v.valid && v.rdy)
        sb.push_back(xfer_t'{v.pc, 32'h100 + 32'(v.pc)});
      if (v.rst) begin
        exp_fetched = 0;
        exp_stall = 0;
      end else if (v.valid) begin
        if (v.rdy) exp_fetched++;
        else exp_stall++;
      end

      @(negedge clk);
      exp_p1 = v.pc + 10'd1;
      check("out_valid", 32'(bus.out_valid), 32'(v.valid));
      check("pc", 32'(bus.pc), 32'(v.pc));
      check("pc_plus1", 32'(bus.pc_plus1), 32'(exp_p1));
      check("imem_addr", 32'(bus.imem_addr), 32'(v.addr));
      check("instr", bus.instr, v.valid ? 32'h100 + 32'(v.pc) : 32'h0);
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_xfer", 32'(bus.pc), 32'hFFFF_FFFF);
        end else begin
          got = sb.pop_front();
          check("sb_pc", 32'(bus.pc), 32'(got.pc));
          check("sb_instr", bus.instr, got.instr);
        end
      end
    end

    @(posedge clk);
    @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
`ifdef FETCH_PERF_EN
    check("perf_fetched", bus.perf_fetched, 32'(exp_fetched));
    check("perf_stall", bus.perf_stall, 32'(exp_stall));
    check("perf_fetched_10", 32'(exp_fetched), 32'd10);
    check("perf_stall_3", 32'(exp_stall), 32'd3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the MIPS CPU. Sits directly upstream of `instructionmemory`: it owns the program counter, drives the memory's word `address` and pairs the returned `dataOut` with its PC. It presents the instruction to decode with a valid/ready handshake. The block also handles pipeline stalls and branch/jump redirects, with a one-cycle squash.

## Interface
- `ADDR_WIDTH`, 10: word-address width; matches `instructionmemory`.
- `DATA_WIDTH`, 32: instruction width.
- `RESET_PC`, 0: word address fetched first after reset.
- `clk` in 1: single clock; everything is sampled on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `imem_addr` out ADDR_WIDTH: drives `instructionmemory.address`. This is combinational `pc_next`.
- `imem_data` in DATA_WIDTH: from `instructionmemory.dataOut`. Holds `mem[address]` sampled at the previous edge.
- `redirect` in 1: branch/jump taken, from a later stage.
- `redirect_pc` in ADDR_WIDTH: target word address, qualified by `redirect`.
- `out_ready` in 1: decode can accept the instruction.
- `out_valid` out 1: `instr`/`pc` are valid this cycle.
- `instr` out DATA_WIDTH: fetched instruction. Forced to 0 when `out_valid`=0.
- `pc` out ADDR_WIDTH: word address of `instr`.
- `pc_plus1` out ADDR_WIDTH: `pc`+1 mod 2^ADDR_WIDTH, used for link.

## Operation
- State machine: FILL, RUN.
  - `rst`=1 at an edge: state←FILL, `pc`←RESET_PC.
  - FILL→RUN unconditionally after one cycle, unless `rst` is high.
- `pc_next` is computed with this priority:
  - `rst`: RESET_PC.
  - `redirect`: `redirect_pc`.
  - FILL: `pc`.
  - RUN and `out_valid` and !`out_ready` (stall): `pc`.
  - RUN otherwise: `pc`+1.
- `imem_addr` = `pc_next`, and `pc` ← `pc_next` every edge. As a result, `imem_data` in any cycle is `mem[pc]`.
- `out_valid` = (state==RUN) && !`redirect` && !`rst`.
  - A redirect squashes the instruction currently presented; it is wrong-path.
- Stall: `pc` is held, so the memory re-reads the same word. `instr`/`pc` therefore stay stable until accepted.
- Handshake rules:
  - A transfer occurs when `out_valid` && `out_ready`.
  - `out_valid` never drops without a transfer, except on `redirect` or `rst`.
- Arithmetic: `pc`+1 truncated to ADDR_WIDTH; 1023+1 wraps to 0. There is no byte addressing; the PC is word-indexed.

## Timing
- Reset values (cycle after the `rst` edge): `out_valid`=0, `instr`=0, `pc`=RESET_PC, `pc_plus1`=RESET_PC+1. `imem_addr`=RESET_PC during the FILL cycle.
- First valid instruction appears 2 cycles after the edge at which `rst` was sampled high: one FILL bubble, then `mem[RESET_PC]` in RUN.
- Throughput: 1 instruction/cycle with `out_ready` held high. Latency from address to data is 1 cycle, fixed by the memory.
- Redirect penalty: exactly 1 bubble.
  - Cycle n: `redirect`=1, `out_valid`=0.
  - Cycle n+1: `instr`=`mem[redirect_pc]`, `out_valid`=1.
- Redirect during stall, or during FILL: the redirect wins; the next cycle presents the target.
- `rst` mid-operation overrides `redirect`/stall in the same cycle. Any in-flight instruction is dropped.
- Back-to-back redirects: each squashes the current cycle. Only the last target is fetched.

## Configuration
- `FETCH_PERF_EN` defined adds two 32-bit outputs:
  - `perf_fetched`: counts transfers.
  - `perf_stall`: counts cycles with `out_valid`&&!`out_ready`.
  - Both clear on `rst` and saturate at 2^32-1.
- `FETCH_PERF_EN` undefined: these ports and counters are absent. Functional behaviour is otherwise identical.

## Test plan
- Reset then free-run, memory preloaded with `mem[k]`=k+0x100, `out_ready`=1:
  - Cycle 1: `out_valid`=0.
  - Then `pc`=0,1,2,… with `instr`=0x100,0x101,… on consecutive cycles.
- Stall: drop `out_ready` for 3 cycles at `pc`=5.
  - `instr`=0x105 and `pc`=5 held for 3 cycles, `imem_addr`=5.
  - On release, `pc`=6 next cycle.
- Redirect to 20 while presenting `pc`=7:
  - That cycle `out_valid`=0.
  - Next cycle `pc`=20, `instr`=0x114; then 21.
- Wrap: redirect to 1022.
  - Sequence is 1022, 1023, 0, 1 with `pc_plus1`=1023, 0, 1, 2.
- Reset asserted during a stall with `redirect`=1:
  - Next cycle `out_valid`=0, `pc`=RESET_PC.
  - Then `mem[RESET_PC]` after one FILL bubble.
- With `FETCH_PERF_EN`: 10 transfers plus 3 stall cycles gives `perf_fetched`=10, `perf_stall`=3.
